alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1 each  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  arbiter accepts requester N's operation this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-007 req0_op / req1_op  input  3 each  ALU control: 000 add, 001 sub, 010 and, 011 or, 100 sll, 101 srl, 110 xor, 111 not.
REQ-008 rsp0_valid / rsp1_valid  output  1 each  result available for requester N.
REQ-009 rsp0_ready / rsp1_ready  input  1 each  requester N consumes its result.
REQ-010 rsp_result  output  WIDTH  captured ALU result, shared by both response channels.
REQ-011 rsp_flags  output  4  captured flags, bit3..0 = n,z,c,v.
REQ-012 alu_a, alu_b  output  WIDTH each  operands driven to the shared combinational ALU.
REQ-013 alu_control  output  3  opcode driven to the shared ALU.
REQ-014 alu_result  input  WIDTH; alu_flags  input  4  combinational ALU outputs.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 grant_id  output  1  requester owning the current or last transaction.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, RESP; encoding is free.
REQ-018 IDLE: when any reqN_valid is high, the arbiter SHALL select a winner and assert only the winner's reqN_ready combinationally in the same cycle; reqN_ready SHALL be 0 in EXEC and RESP.
REQ-019 Arbitration SHALL be round-robin: with both valid, the requester not equal to last_grant wins; with one valid, that requester wins regardless of last_grant.
REQ-020 On acceptance (valid and ready), a, b and op of the winner SHALL be registered into alu_a, alu_b and alu_control; grant_id and last_grant SHALL become the winner; the FSM SHALL go to EXEC.
REQ-021 EXEC SHALL last exactly one cycle; at its end, rsp_result and rsp_flags SHALL capture alu_result and alu_flags; the FSM SHALL go to RESP.
REQ-022 RESP: rsp<grant_id>_valid SHALL be high and the other rsp valid low; rsp_result and rsp_flags SHALL stay stable until the handshake.
REQ-023 RESP exit: when rsp<grant_id>_ready is high, the FSM SHALL return to IDLE next cycle; ready from the non-granted requester SHALL be ignored.
REQ-024 Latency: accept in cycle T, capture at end of T+1, rsp valid in T+2; minimum issue interval 3 cycles per operation.
REQ-025 alu_a, alu_b, alu_control SHALL hold their last registered values outside acceptance (no toggling in IDLE/RESP).
REQ-026 rsp_ready already high when rsp_valid rises SHALL complete the handshake in that same cycle.
REQ-027 A requester dropping valid while not granted SHALL incur no side effects; it is not tracked as pending.
REQ-028 A requester may keep valid high during its own RESP; it SHALL be re-arbitrated only in IDLE, where round-robin gives the other requester priority if both are valid.
REQ-029 The arbiter SHALL perform no arithmetic itself; WIDTH-wide values pass through unmodified.

Reset
REQ-030 While rst_n is low at a rising edge, the FSM SHALL enter IDLE; alu_a, alu_b, rsp_result = 0; alu_control = 000; rsp_flags = 0000; grant_id = 0; last_grant = 1 (so requester 0 wins the first tie).
REQ-031 During and right after reset: all ready/valid outputs = 0 and busy = 0 until the first IDLE arbitration.
REQ-032 Reset in EXEC or RESP SHALL abandon the transaction; no response for it SHALL ever be produced.

Verification
REQ-033 After reset, both valid together (req0 add 5,3; req1 sub 5,3) -> req0 accepted first, rsp0 result 8, flags 0000; then req1 accepted, rsp1 result 2, flags 0010.
REQ-034 req0 alone repeatedly, rsp0_ready held high -> one accept every 3 cycles; rsp0_valid exactly 2 cycles after each accept.
REQ-035 req1 sub 3,5, rsp1_ready held low 4 cycles -> rsp1_valid high 4+ cycles, result 0xFFFFFFFE, flags 1000 stable; no new accept.
REQ-036 rst_n low for one cycle during EXEC -> no rsp valid afterwards; all outputs at reset values; next request is served normally.
REQ-037 req0 xor 0xFFFF0000,0x0F0F0F0F; req1 not 0 asserted concurrently for 3 transactions -> grants alternate 0,1,0; results 0xF0F00F0F, 0xFFFFFFFF.
REQ-038 rsp0_ready pulsed during requester-1 RESP -> ignored; rsp1_valid remains high until rsp1_ready.

Source files
------------

// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin arbiter that lets two requesters share one
//                external combinational ALU (accept / execute / respond).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,

    output logic             busy,
    output logic             grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;
    logic             w_any_req;
    logic             w_winner;
    logic             w_accept;
    logic             w_rsp_ready_sel;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [2:0]       w_sel_op;

    // With a tie the requester that did not win last time goes first;
    // a lone requester wins regardless of history.
    assign w_any_req = req0_valid | req1_valid;
    assign w_winner  = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

    assign w_sel_a  = w_winner ? req1_a  : req0_a;
    assign w_sel_b  = w_winner ? req1_b  : req0_b;
    assign w_sel_op = w_winner ? req1_op : req0_op;

    // Only the owner's ready may release the response.
    assign w_rsp_ready_sel = grant_id ? rsp1_ready : rsp0_ready;

    assign busy = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Ready is held low while reset is asserted.
                if (rst_n && w_any_req) begin
                    w_accept    = 1'b1;
                    req0_ready  = ~w_winner;
                    req1_ready  = w_winner;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp0_valid = ~grant_id;
                rsp1_valid = grant_id;
                if (w_rsp_ready_sel) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            grant_id     <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_control  <= 3'b000;
            rsp_result   <= '0;
            rsp_flags    <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                alu_a        <= w_sel_a;
                alu_b        <= w_sel_b;
                alu_control  <= w_sel_op;
                grant_id     <= w_winner;
                r_last_grant <= w_winner;
            end
            // The ALU has had the whole EXEC cycle to settle on the operands.
            if (r_state == ST_EXEC) begin
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter with a reference ALU and
//                a transaction-level model compared on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_control;
    logic [3:0]  alu_flags;
    logic        busy;
    logic        grant_id;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit cmp_en   = 0;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .busy(busy), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU: returns {n,z,c,v, result}; subtract carry = no borrow.
    function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        s = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b001: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a << b[4:0];
            3'b101:  r = a >> b[4:0];
            3'b110:  r = a ^ b;
            default: r = ~a;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    assign {alu_flags, alu_result} = ref_alu(alu_a, alu_b, alu_control);

    // Transaction model: one outstanding operation, age counts cycles since accept.
    bit          m_active;
    int          m_age;
    bit          m_owner;
    bit          m_last;
    logic [31:0] m_a, m_b, m_res;
    logic [2:0]  m_op;
    logic [3:0]  m_flags;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active <= 0; m_age <= 0; m_owner <= 0; m_last <= 1;
            m_a <= '0; m_b <= '0; m_op <= '0; m_res <= '0; m_flags <= '0;
        end else if (!m_active) begin
            if (req0_valid || req1_valid) begin
                bit w;
                w = (req0_valid && req1_valid) ? !m_last : req1_valid;
                m_owner  <= w;
                m_last   <= w;
                m_a      <= w ? req1_a  : req0_a;
                m_b      <= w ? req1_b  : req0_b;
                m_op     <= w ? req1_op : req0_op;
                m_active <= 1;
                m_age    <= 0;
            end
        end else begin
            m_age <= m_age + 1;
            if (m_age == 0) {m_flags, m_res} <= ref_alu(m_a, m_b, m_op);
            if (m_age >= 1 && (m_owner ? rsp1_ready : rsp0_ready)) m_active <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            bit idle;
            idle = !m_active;
            chk("req0_ready", 32'(req0_ready),
                32'(rst_n && idle && req0_valid && (!req1_valid || m_last)));
            chk("req1_ready", 32'(req1_ready),
                32'(rst_n && idle && req1_valid && (!req0_valid || !m_last)));
            chk("rsp0_valid", 32'(rsp0_valid), 32'(m_active && m_age >= 1 && !m_owner));
            chk("rsp1_valid", 32'(rsp1_valid), 32'(m_active && m_age >= 1 && m_owner));
            chk("busy", 32'(busy), 32'(m_active));
            chk("grant_id", 32'(grant_id), 32'(m_owner));
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_control", 32'(alu_control), 32'(m_op));
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_flags", 32'(rsp_flags), 32'(m_flags));
        end
    end

    task automatic wait_accept(input int id, input bit drop, output int acc_cyc);
        bit got;
        got = 0;
        acc_cyc = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (id == 0 ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) begin
                got = 1;
                acc_cyc = cyc;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL accept%0d actual=timeout required=handshake", id);
        end
        @(posedge clk);
        #1;
        if (drop) begin
            if (id == 0) req0_valid = 0;
            else         req1_valid = 0;
        end
    endtask

    task automatic wait_any(output int id);
        bit got;
        got = 0;
        id = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready)      begin got = 1; id = 0; end
            else if (req1_valid && req1_ready) begin got = 1; id = 1; end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL accept_any actual=timeout required=handshake");
        end
    endtask

    task automatic wait_rsp(input int id, input logic [31:0] er, input logic [3:0] ef,
                            output int rsp_cyc);
        bit got;
        got = 0;
        rsp_cyc = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (id == 0 ? rsp0_valid : rsp1_valid) begin
                got = 1;
                rsp_cyc = cyc;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rsp%0d actual=timeout required=valid", id);
        end else begin
            chk("lit_result", rsp_result, er);
            chk("lit_flags", 32'(rsp_flags), 32'(ef));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ac, rc, id;
        logic [31:0] exp34 [4];
        logic [31:0] exp37 [3];
        int          ord37 [3];
        exp34 = '{32'd6, 32'd19, 32'd32, 32'd45};
        exp37 = '{32'hF0F00F0F, 32'hFFFFFFFF, 32'hF0F00F0F};
        ord37 = '{0, 1, 0};

        rst_n = 0;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        rsp0_ready = 0; rsp1_ready = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 cmp_en = 1;
        req0_valid = 1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_req0_ready", 32'(req0_ready), 32'd0);
        chk("reset_grant", 32'(grant_id), 32'd0);
        chk("reset_alu_ctl", 32'(alu_control), 32'd0);
        chk("reset_result", rsp_result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;

        // Tie after reset: req0 first, then req1
        req0_a = 5; req0_b = 3; req0_op = 3'b000; req0_valid = 1;
        req1_a = 5; req1_b = 3; req1_op = 3'b001; req1_valid = 1;
        rsp0_ready = 1; rsp1_ready = 1;
        wait_accept(0, 1, ac);
        wait_rsp(0, 32'd8, 4'b0000, rc);
        wait_accept(1, 1, ac);
        wait_rsp(1, 32'd2, 4'b0010, rc);

        // Back-to-back single requester: issue interval and latency
        @(posedge clk); #1;
        req0_a = 5; req0_b = 1; req0_op = 3'b000; req0_valid = 1;
        begin
            int prev;
            prev = 0;
            for (int k = 0; k < 4; k++) begin
                wait_accept(0, k == 3, ac);
                if (k > 0) chk("issue_interval", 32'(ac - prev), 32'd3);
                prev = ac;
                req0_a = 32'(10 * (k + 1) + 5);
                req0_b = 32'(3 * (k + 1) + 1);
                wait_rsp(0, exp34[k], 4'b0000, rc);
                chk("rsp_latency", 32'(rc - ac), 32'd2);
            end
        end

        // Stalled response; foreign ready ignored; other requester waits
        @(posedge clk); #1;
        rsp0_ready = 0; rsp1_ready = 0;
        req1_a = 3; req1_b = 5; req1_op = 3'b001; req1_valid = 1;
        wait_accept(1, 1, ac);
        req0_a = 5; req0_b = 3; req0_op = 3'b000; req0_valid = 1;
        wait_rsp(1, 32'hFFFFFFFE, 4'b1000, rc);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            rsp0_ready = (i == 1);
            @(negedge clk);
            chk("stall_rsp1_valid", 32'(rsp1_valid), 32'd1);
            chk("stall_req0_ready", 32'(req0_ready), 32'd0);
            chk("stall_result", rsp_result, 32'hFFFFFFFE);
            chk("stall_flags", 32'(rsp_flags), 32'h8);
        end
        @(posedge clk); #1;
        rsp0_ready = 1; rsp1_ready = 1;
        wait_accept(0, 1, ac);
        wait_rsp(0, 32'd8, 4'b0000, rc);

        // Reset during EXEC abandons the transaction
        @(posedge clk); #1;
        req0_a = 1; req0_b = 2; req0_op = 3'b000; req0_valid = 1;
        wait_accept(0, 1, ac);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_rsp0", 32'(rsp0_valid), 32'd0);
            chk("post_reset_busy", 32'(busy), 32'd0);
            chk("post_reset_result", rsp_result, 32'd0);
            chk("post_reset_alu_a", alu_a, 32'd0);
        end
        @(posedge clk); #1;
        req1_a = 7; req1_b = 12; req1_op = 3'b010; req1_valid = 1;
        wait_accept(1, 1, ac);
        wait_rsp(1, 32'd4, 4'b0000, rc);
        chk("lit_grant_after_reset", 32'(grant_id), 32'd1);

        // Both requesters persistently valid: grants alternate
        @(posedge clk); #1;
        req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F; req0_op = 3'b110; req0_valid = 1;
        req1_a = 32'h0;        req1_b = 32'h0;        req1_op = 3'b111; req1_valid = 1;
        for (int k = 0; k < 3; k++) begin
            wait_any(id);
            chk("rr_order", 32'(id), 32'(ord37[k]));
            if (k == 2) begin
                @(posedge clk); #1;
                req0_valid = 0; req1_valid = 0;
            end
            wait_rsp(ord37[k], exp37[k], 4'b1000, rc);
            chk("rr_grant_id", 32'(grant_id), 32'(ord37[k]));
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
